decode_seq_ctrl: RTL and testbench
==================================

DECODE_SEQ_CTRL -- requirements
Module: decode_seq_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 4, key stable-cycle count before acceptance; legal range 1..255.
REQ-002 Parameter TICK_DIV, default 8, clock cycles per scan step; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 key_in  input  3  raw switch code; asynchronous to the block's function, no synchronizer required in this block.
REQ-006 mode  input  2  00 none, 01 manual, 10 scan-up, 11 scan-down; sampled only with start.
REQ-007 start  input  1  single-cycle request to leave IDLE.
REQ-008 stop  input  1  return to IDLE.
REQ-009 sel  output  3  registered select code driving the 3-8 decoder keyin port.
REQ-010 busy  output  1  registered; 1 in any state other than IDLE.
REQ-011 step  output  1  registered one-cycle pulse on every sel change.
REQ-012 wrap  output  1  registered one-cycle pulse on a scan transition 7->0 (up) or 0->7 (down).

Function
REQ-013 FSM states SHALL be IDLE, MANUAL, SCAN_UP, SCAN_DN; encoding free.
REQ-014 IDLE: start=1 with mode 01/10/11 -> MANUAL/SCAN_UP/SCAN_DN next edge; mode 00 stays IDLE.
REQ-015 start in a non-IDLE state SHALL be ignored; mode changes outside start SHALL have no effect.
REQ-016 stop=1 in any state -> IDLE next edge; stop has priority over start, tick and debounce updates in the same cycle (no sel change, no step).
REQ-017 sel SHALL hold its value in IDLE and across all state transitions.
REQ-018 Debounce: key_q (3 b) and deb_cnt (8 b) run every cycle in every state; key_in != key_q -> key_q<=key_in, deb_cnt<=0; else deb_cnt increments, saturating at DEB_CYC-1.
REQ-019 MANUAL: when key_in == key_q, deb_cnt == DEB_CYC-1 and key_q != sel -> sel<=key_q, step=1 that edge.
REQ-020 Consequence: a new value V held constant from edge k SHALL appear on sel after edge k+DEB_CYC; a pulse shorter than DEB_CYC+1 cycles SHALL never reach sel.
REQ-021 Entering MANUAL with a key already stable and different from sel SHALL update sel on the first edge in MANUAL.
REQ-022 SCAN: tick_cnt (16 b) cleared on entry to SCAN_UP/SCAN_DN; increments each cycle; at tick_cnt == TICK_DIV-1 -> tick_cnt<=0, sel<=sel+1 (UP) or sel-1 (DN) modulo 8, step=1.
REQ-023 First scan step SHALL occur TICK_DIV edges after busy rises; then one step every TICK_DIV cycles; TICK_DIV=1 steps every cycle.
REQ-024 wrap SHALL pulse together with step only on 7->0 in SCAN_UP or 0->7 in SCAN_DN; never in MANUAL.
REQ-025 step and wrap SHALL be 0 in every cycle without a sel change; no step when the accepted key equals sel.
REQ-026 tick_cnt SHALL hold (not count) outside SCAN states.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, sel=000, busy=0, step=0, wrap=0, key_q=000, deb_cnt=0, tick_cnt=0, regardless of clk.
REQ-028 Reset asserted mid-scan or mid-debounce SHALL discard all progress; after release the block waits in IDLE for start.
REQ-029 First edge after rst_n rises SHALL behave as a normal IDLE cycle.

Verification (defaults DEB_CYC=4, TICK_DIV=8)
REQ-030 Reset, then start with mode=10, stop low -> busy=1 next edge; sel 0->1 after 8 edges, then 2..7,0 every 8 cycles; wrap pulses exactly on 7->0.
REQ-031 start mode=11 from sel=0 -> first step sel=7 with wrap=1, then 6, 5, ... every 8 cycles.
REQ-032 start mode=01; key_in=101 held -> sel=101, step=1 after edge 4 from first sampling; key_in glitch 011 for 3 cycles then back -> sel unchanged, no step.
REQ-033 In SCAN_UP, assert stop and start in the same cycle where tick_cnt=7 -> IDLE, busy=0, sel not incremented, no step; sel then held.
REQ-034 start while in MANUAL with mode=10 -> ignored, state stays MANUAL, no change in tick_cnt.
REQ-035 Assert rst_n=0 mid-cycle during SCAN_UP with sel=5 -> sel=0, busy=0 immediately without clock edge; after release, no activity until start.

Source files
------------

// File: rtl/decode_seq_ctrl.sv
// decode_seq_ctrl
//   Produces the select code for a 3-8 decoder. The code comes either from a
//   debounced key (manual mode) or from a free-running up/down scan.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start; sel held; debouncer keeps tracking key
//   ST_MANUAL  | sel follows the debounced key_in
//   ST_SCAN_UP | sel += 1 (mod 8) every TICK_DIV cycles; wrap on 7->0
//   ST_SCAN_DN | sel -= 1 (mod 8) every TICK_DIV cycles; wrap on 0->7
//
//   Ports
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     key_in  raw 3-bit switch code
//     mode    00 none, 01 manual, 10 scan-up, 11 scan-down (sampled with start)
//     start   one-cycle request to leave IDLE
//     stop    return to IDLE; highest priority
//     sel     registered decoder select
//     busy    registered, high outside IDLE
//     step    one-cycle pulse on every sel change
//     wrap    one-cycle pulse on a scan wrap-around

`timescale 1ns/1ps

module decode_seq_ctrl #(
   parameter int unsigned DEB_CYC  = 4,
   parameter int unsigned TICK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] key_in,
   input  logic [1:0] mode,
   input  logic       start,
   input  logic       stop,
   output logic [2:0] sel,
   output logic       busy,
   output logic       step,
   output logic       wrap
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_MANUAL  = 2'b01,
      ST_SCAN_UP = 2'b10,
      ST_SCAN_DN = 2'b11
   } state_t;

   // Both timers count down to a terminal count of zero. deb_rem == 0 means
   // the key has been stable for DEB_CYC-1 further cycles after capture.
   localparam logic [7:0]  DEB_LOAD  = 8'(DEB_CYC - 1);
   localparam logic [15:0] TICK_LOAD = 16'(TICK_DIV - 1);

   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic        busy_q, busy_d;
   logic        step_q, step_d;
   logic        wrap_q, wrap_d;
   logic [2:0]  key_q, key_d;
   logic [7:0]  deb_rem_q, deb_rem_d;
   logic [15:0] tick_rem_q, tick_rem_d;
   logic        key_stable;

   // Debouncer runs in every state so a key settled while idle is accepted
   // on the first edge in MANUAL.
   always_comb begin
      key_d     = key_q;
      deb_rem_d = deb_rem_q;
      if (key_in != key_q) begin
         key_d     = key_in;
         deb_rem_d = DEB_LOAD;
      end else if (deb_rem_q != 8'd0) begin
         deb_rem_d = deb_rem_q - 8'd1;
      end
   end

   assign key_stable = (key_in == key_q) && (deb_rem_q == 8'd0);

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      step_d     = 1'b0;
      wrap_d     = 1'b0;
      tick_rem_d = tick_rem_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               unique case (mode)
                  2'b01: state_d = ST_MANUAL;
                  2'b10: begin
                     state_d    = ST_SCAN_UP;
                     tick_rem_d = TICK_LOAD;
                  end
                  2'b11: begin
                     state_d    = ST_SCAN_DN;
                     tick_rem_d = TICK_LOAD;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end
         end
         ST_MANUAL: begin
            if (key_stable && (key_q != sel_q)) begin
               sel_d  = key_q;
               step_d = 1'b1;
            end
         end
         ST_SCAN_UP: begin
            if (tick_rem_q == 16'd0) begin
               tick_rem_d = TICK_LOAD;
               sel_d      = sel_q + 3'd1;
               step_d     = 1'b1;
               wrap_d     = (sel_q == 3'd7);
            end else begin
               tick_rem_d = tick_rem_q - 16'd1;
            end
         end
         ST_SCAN_DN: begin
            if (tick_rem_q == 16'd0) begin
               tick_rem_d = TICK_LOAD;
               sel_d      = sel_q - 3'd1;
               step_d     = 1'b1;
               wrap_d     = (sel_q == 3'd0);
            end else begin
               tick_rem_d = tick_rem_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // stop overrides everything decided above for this cycle.
      if (stop) begin
         state_d    = ST_IDLE;
         sel_d      = sel_q;
         step_d     = 1'b0;
         wrap_d     = 1'b0;
         tick_rem_d = tick_rem_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= 3'd0;
         busy_q     <= 1'b0;
         step_q     <= 1'b0;
         wrap_q     <= 1'b0;
         key_q      <= 3'd0;
         deb_rem_q  <= DEB_LOAD;
         tick_rem_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
         key_q      <= key_d;
         deb_rem_q  <= deb_rem_d;
         tick_rem_q <= tick_rem_d;
      end
   end

   assign sel  = sel_q;
   assign busy = busy_q;
   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_decode_seq_ctrl.sv
// tb_decode_seq_ctrl
//   Directed bench for decode_seq_ctrl at DEB_CYC=4, TICK_DIV=8.
//   Inputs change and outputs are sampled on the falling clock edge.

`timescale 1ns/1ps

module tb_decode_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic [2:0] key_in;
   logic [1:0] mode;
   logic       start;
   logic       stop;
   logic [2:0] sel;
   logic       busy;
   logic       step;
   logic       wrap;

   int n_tests = 0;
   int n_fail  = 0;

   decode_seq_ctrl #(
      .DEB_CYC  (4),
      .TICK_DIV (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (key_in),
      .mode   (mode),
      .start  (start),
      .stop   (stop),
      .sel    (sel),
      .busy   (busy),
      .step   (step),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b1;
      key_in = 3'd0;
      mode   = 2'b00;
      start  = 1'b0;
      stop   = 1'b0;

      // asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk3("rst_sel",  sel,  3'd0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_step", step, 1'b0);
      chk1("rst_wrap", wrap, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc();
      cyc();
      chk1("idle_busy", busy, 1'b0);
      chk3("idle_sel",  sel,  3'd0);

      // scan up through a full revolution
      start = 1'b1; mode = 2'b10;
      cyc();
      start = 1'b0; mode = 2'b00;
      chk1("up_busy",  busy, 1'b1);
      chk3("up_sel0",  sel,  3'd0);
      chk1("up_step0", step, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         repeat (7) cyc();
         chk3("up_hold_sel",  sel,  3'(k - 1));
         chk1("up_hold_step", step, 1'b0);
         cyc();
         chk3("up_sel",  sel,  3'(k));
         chk1("up_step", step, 1'b1);
         chk1("up_wrap", wrap, (k == 8));
      end

      // stop together with start on the terminal tick
      repeat (7) cyc();
      stop = 1'b1; start = 1'b1; mode = 2'b10;
      cyc();
      stop = 1'b0; start = 1'b0; mode = 2'b00;
      chk1("stop_busy", busy, 1'b0);
      chk3("stop_sel",  sel,  3'd0);
      chk1("stop_step", step, 1'b0);
      repeat (10) cyc();
      chk3("stop_hold_sel",  sel,  3'd0);
      chk1("stop_hold_busy", busy, 1'b0);

      // scan down from 0
      start = 1'b1; mode = 2'b11;
      cyc();
      start = 1'b0; mode = 2'b00;
      chk1("dn_busy", busy, 1'b1);
      repeat (7) cyc();
      chk3("dn_hold_sel",  sel,  3'd0);
      chk1("dn_hold_step", step, 1'b0);
      cyc();
      chk3("dn_sel7",  sel,  3'd7);
      chk1("dn_step7", step, 1'b1);
      chk1("dn_wrap7", wrap, 1'b1);
      for (int v = 6; v >= 4; v--) begin
         repeat (7) cyc();
         chk1("dn_gap_step", step, 1'b0);
         cyc();
         chk3("dn_sel",  sel,  3'(v));
         chk1("dn_step", step, 1'b1);
         chk1("dn_wrap", wrap, 1'b0);
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk1("dn_stop_busy", busy, 1'b0);
      chk3("dn_stop_sel",  sel,  3'd4);

      // manual: key 101 accepted DEB_CYC edges after first sampling
      start = 1'b1; mode = 2'b01; key_in = 3'b101;
      cyc();
      start = 1'b0; mode = 2'b00;
      chk1("man_busy",  busy, 1'b1);
      chk3("man_sel0",  sel,  3'd4);
      chk1("man_step0", step, 1'b0);
      repeat (3) cyc();
      chk3("man_sel3",  sel,  3'd4);
      chk1("man_step3", step, 1'b0);
      cyc();
      chk3("man_sel4",  sel,  3'd5);
      chk1("man_step4", step, 1'b1);
      chk1("man_wrap4", wrap, 1'b0);
      cyc();
      chk1("man_step5", step, 1'b0);

      // 3-cycle glitch never reaches sel
      key_in = 3'b011;
      repeat (3) cyc();
      key_in = 3'b101;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk3("glitch3_sel",  sel,  3'd5);
         chk1("glitch3_step", step, 1'b0);
      end

      // DEB_CYC+1 cycle pulse is accepted on its last edge
      key_in = 3'b011;
      repeat (4) cyc();
      chk3("pulse5_sel_early", sel, 3'd5);
      cyc();
      chk3("pulse5_sel",  sel,  3'd3);
      chk1("pulse5_step", step, 1'b1);
      key_in = 3'b101;
      repeat (4) cyc();
      chk3("back_sel_early", sel, 3'd3);
      cyc();
      chk3("back_sel",  sel,  3'd5);
      chk1("back_step", step, 1'b1);

      // start in MANUAL is ignored
      start = 1'b1; mode = 2'b10;
      cyc();
      start = 1'b0; mode = 2'b00;
      chk1("ign_busy", busy, 1'b1);
      repeat (12) cyc();
      chk3("ign_sel",  sel,  3'd5);
      chk1("ign_step", step, 1'b0);

      // key settled in IDLE is taken on first edge in MANUAL
      stop = 1'b1; key_in = 3'b010;
      cyc();
      stop = 1'b0;
      chk1("pre_busy", busy, 1'b0);
      repeat (6) cyc();
      chk3("idle_key_sel", sel, 3'd5);
      start = 1'b1; mode = 2'b01;
      cyc();
      start = 1'b0; mode = 2'b00;
      chk3("entry_sel0",  sel,  3'd5);
      chk1("entry_busy",  busy, 1'b1);
      chk1("entry_step0", step, 1'b0);
      cyc();
      chk3("entry_sel1",  sel,  3'd2);
      chk1("entry_step1", step, 1'b1);

      // asynchronous reset mid-scan at sel=5
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      start = 1'b1; mode = 2'b10;
      cyc();
      start = 1'b0; mode = 2'b00;
      repeat (24) cyc();
      chk3("mid_sel", sel, 3'd5);
      #2 rst_n = 1'b0;
      #1;
      chk3("async_sel",  sel,  3'd0);
      chk1("async_busy", busy, 1'b0);
      chk1("async_step", step, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) cyc();
      chk1("post_busy", busy, 1'b0);
      chk3("post_sel",  sel,  3'd0);
      chk1("post_step", step, 1'b0);
      start = 1'b1; mode = 2'b10;
      cyc();
      start = 1'b0; mode = 2'b00;
      chk1("restart_busy", busy, 1'b1);
      repeat (7) cyc();
      chk3("restart_hold", sel, 3'd0);
      cyc();
      chk3("restart_sel",  sel,  3'd1);
      chk1("restart_step", step, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
